// File: rtl/triple_pkg.sv
// ============================================================================
//  Module      : triple_pkg
//  Description : Shared types and constants for the triple sampler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package triple_pkg;

    localparam int TRIPLE_LEN = 3;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    typedef logic [1:0] fill_cnt_t;

    // Fill count at which the next accepted sample completes a triple
    localparam fill_cnt_t c_LAST_FILL = fill_cnt_t'(TRIPLE_LEN - 1);

endpackage

`default_nettype wire

// File: rtl/minority_vote.sv
// ============================================================================
//  Module      : minority_vote
//  Description : 3-input minority: y=1 when at most one input is 1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module minority_vote (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = ~((a & b) | (b & c) | (a & c));

endmodule

`default_nettype wire

// File: rtl/triple_sampler.sv
// ============================================================================
//  Module      : triple_sampler
//  Description : Groups serial samples into registered triples with minority
//                output and a saturating consumed-triple counter.
//                Optional output parity under TRIPLE_SAMPLER_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module triple_sampler
    import triple_pkg::*;
#(
    parameter int TCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              y_min,
`ifdef TRIPLE_SAMPLER_PARITY_EN
    output logic              parity,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TCNT_W-1:0] tcnt
);

    out_state_t        r_state;
    out_state_t        w_state_nxt;
    fill_cnt_t         r_count;
    logic              r_stage1;
    logic              r_stage2;
    logic              r_a;
    logic              r_b;
    logic              r_c;
    logic [TCNT_W-1:0] r_tcnt;
    logic              w_accept;
    logic              w_complete;
    logic              w_handshake;
    logic              w_last;

    assign w_last      = (r_count == c_LAST_FILL);
    // Only a completing sample needs room in the output register
    assign in_ready    = ~(w_last && (r_state == FULL) && ~out_ready);
    assign w_accept    = in_valid & in_ready;
    assign w_complete  = w_accept & ~clr & w_last;
    assign out_valid   = (r_state == FULL);
    assign w_handshake = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_stage1 <= 1'b0;
            r_stage2 <= 1'b0;
        end else if (clr) begin
            r_count  <= '0;
            r_stage1 <= 1'b0;
            r_stage2 <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 2'd1;
                if (r_count == 2'd0) begin
                    r_stage1 <= in_bit;
                end else begin
                    r_stage2 <= in_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_complete) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready && !w_complete) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
            r_c <= 1'b0;
        end else if (w_complete) begin
            r_a <= r_stage1;
            r_b <= r_stage2;
            r_c <= in_bit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
        end else if (w_handshake && (r_tcnt != '1)) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

`ifdef TRIPLE_SAMPLER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (w_complete) begin
            r_parity <= r_stage1 ^ r_stage2 ^ in_bit;
        end
    end

    assign parity = r_parity;
`endif

    assign a    = r_a;
    assign b    = r_b;
    assign c    = r_c;
    assign tcnt = r_tcnt;

    minority_vote u_minority (
        .a (r_a),
        .b (r_b),
        .c (r_c),
        .y (y_min)
    );

endmodule

`default_nettype wire
